// File: rtl/huffman_ctrl_param.sv
// Control sequencer for the Huffman coding datapath.
// Walks count -> count-valid -> sort -> decode -> code-output for NUM_SYM
// symbols, counts pixels per image with saturation and a sticky overflow
// flag, and optionally holds code_valid until the consumer acknowledges.
module huffman_ctrl_param #(
    parameter int NUM_SYM   = 6,
    parameter int STEP_W    = 3,
    parameter int MAX_PIX   = 100,
    parameter int PIX_W     = 7,
    parameter int HOLD_CODE = 0
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              gray_valid,
    input  logic              code_ack,
    output logic              CNT_valid,
    output logic              code_valid,
    output logic [2:0]        state,
    output logic [STEP_W-1:0] counter,
    output logic [PIX_W-1:0]  pix_cnt,
    output logic              ovf,
    output logic              busy
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        COUNT  = 3'd1,
        CNTV   = 3'd2,
        SORT   = 3'd3,
        DECODE = 3'd4,
        CODEV  = 3'd5
    } state_t;

    localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(NUM_SYM - 2);
    localparam logic [PIX_W-1:0]  PIX_LIMIT = PIX_W'(MAX_PIX);

    state_t             cur_st;
    state_t             nxt_st;
    logic [STEP_W-1:0]  counter_n;
    logic [PIX_W-1:0]   pix_cnt_n;
    logic               ovf_n;
    logic               cnt_valid_n;
    logic               code_valid_n;

    assign state = cur_st;
    assign busy  = (cur_st != IDLE);

    // State and registered outputs; asynchronous clear on reset_n low.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cur_st     <= IDLE;
            counter    <= '0;
            pix_cnt    <= '0;
            ovf        <= 1'b0;
            CNT_valid  <= 1'b0;
            code_valid <= 1'b0;
        end else begin
            cur_st     <= nxt_st;
            counter    <= counter_n;
            pix_cnt    <= pix_cnt_n;
            ovf        <= ovf_n;
            CNT_valid  <= cnt_valid_n;
            code_valid <= code_valid_n;
        end
    end

    // Next-state and next-output decode; pulses default low, counts hold.
    always_comb begin
        nxt_st       = cur_st;
        counter_n    = counter;
        pix_cnt_n    = pix_cnt;
        ovf_n        = ovf;
        cnt_valid_n  = 1'b0;
        code_valid_n = 1'b0;
        case (cur_st)
            IDLE: begin
                counter_n = '0;
                if (gray_valid) begin
                    nxt_st    = COUNT;
                    pix_cnt_n = PIX_W'(1);
                    ovf_n     = 1'b0;
                end
            end
            COUNT: begin
                counter_n = '0;
                if (gray_valid) begin
                    if (pix_cnt < PIX_LIMIT) begin
                        pix_cnt_n = pix_cnt + 1'b1;
                    end else begin
                        ovf_n = 1'b1;
                    end
                end else begin
                    nxt_st      = CNTV;
                    cnt_valid_n = 1'b1;
                end
            end
            CNTV: begin
                counter_n = '0;
                nxt_st    = SORT;
            end
            SORT: begin
                if (counter == LAST_STEP) begin
                    nxt_st = DECODE;
                end else begin
                    counter_n = counter + 1'b1;
                end
            end
            DECODE: begin
                if (counter == '0) begin
                    nxt_st       = CODEV;
                    code_valid_n = 1'b1;
                end else begin
                    counter_n = counter - 1'b1;
                end
            end
            CODEV: begin
                counter_n = '0;
                if ((HOLD_CODE != 0) && !code_ack) begin
                    code_valid_n = 1'b1;
                end else begin
                    nxt_st = IDLE;
                end
            end
            default: begin
                nxt_st    = IDLE;
                counter_n = '0;
                pix_cnt_n = '0;
                ovf_n     = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_huffman_ctrl_param.sv
// Directed bench for huffman_ctrl_param: three instances (default, held
// code_valid, eight symbols). Each image pushes its expected pixel count,
// overflow flag and latency to a scoreboard popped when CNT_valid appears.
module tb_huffman_ctrl_param;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       gv    [3];
    logic       ack   [3];
    logic       cntv  [3];
    logic       cv    [3];
    logic [2:0] st    [3];
    logic [2:0] ctr   [3];
    logic [6:0] pc    [3];
    logic       ovf_o [3];
    logic       busy_o[3];

    typedef struct {
        int   pix;
        logic ovf;
        int   lat;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    huffman_ctrl_param dut0 (
        .clk(clk), .reset_n(rst_n), .gray_valid(gv[0]), .code_ack(ack[0]),
        .CNT_valid(cntv[0]), .code_valid(cv[0]), .state(st[0]), .counter(ctr[0]),
        .pix_cnt(pc[0]), .ovf(ovf_o[0]), .busy(busy_o[0])
    );

    huffman_ctrl_param #(.HOLD_CODE(1)) dut1 (
        .clk(clk), .reset_n(rst_n), .gray_valid(gv[1]), .code_ack(ack[1]),
        .CNT_valid(cntv[1]), .code_valid(cv[1]), .state(st[1]), .counter(ctr[1]),
        .pix_cnt(pc[1]), .ovf(ovf_o[1]), .busy(busy_o[1])
    );

    huffman_ctrl_param #(.NUM_SYM(8), .STEP_W(3)) dut2 (
        .clk(clk), .reset_n(rst_n), .gray_valid(gv[2]), .code_ack(ack[2]),
        .CNT_valid(cntv[2]), .code_valid(cv[2]), .state(st[2]), .counter(ctr[2]),
        .pix_cnt(pc[2]), .ovf(ovf_o[2]), .busy(busy_o[2])
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] outs(input int d);
        return {15'd0, st[d], ctr[d], pc[d], cntv[d], cv[d], ovf_o[d], busy_o[d]};
    endfunction

    // One image on instance d: burst of npix pixels, then follow it to IDLE.
    task automatic run_image(input int d, input int npix, input int nsym,
                             input int hold, input bit tog);
        exp_t e;
        int   k;
        int   bad;
        bit   seen;
        logic [2:0] est;
        logic [2:0] ectr;
        e.pix = (npix > 100) ? 100 : npix;
        e.ovf = (npix > 100);
        e.lat = 2 * nsym - 1;
        sb.push_back(e);

        @(negedge clk);
        gv[d] = 1'b1;
        for (int i = 1; i <= npix; i++) begin
            @(negedge clk);
            if (i == 1)
                chk("first_pix", {21'd0, pc[d], ovf_o[d], st[d]}, {21'd0, 7'd1, 1'b0, 3'd1});
            if (i == 100 && npix > 100)
                chk("pix_at_max", {24'd0, pc[d], ovf_o[d]}, {24'd0, 7'd100, 1'b0});
            if (i == 101)
                chk("ovf_set", {24'd0, pc[d], ovf_o[d]}, {24'd0, 7'd100, 1'b1});
            if (i == npix) gv[d] = 1'b0;
        end

        seen = 1'b0;
        for (int w = 0; w < 4 && !seen; w++) begin
            @(negedge clk);
            seen = cntv[d];
        end
        chk("cntv_seen", {31'd0, seen}, 32'd1);
        if (!seen) return;
        if (sb.size() == 0) begin
            chk("sb_underflow", 32'd1, {31'd0, seen} - 32'd1);
            return;
        end
        e = sb.pop_front();
        chk("cntv_pix", {24'd0, pc[d], ovf_o[d]}, {24'd0, 7'(e.pix), e.ovf});
        chk("cntv_state", {26'd0, st[d], ctr[d]}, {26'd0, 3'd2, 3'd0});

        bad  = 0;
        k    = 0;
        seen = 1'b0;
        while (!seen && k < 40) begin
            if (tog) gv[d] = k[0];
            @(negedge clk);
            k++;
            seen = cv[d];
            if (!seen) begin
                if (k <= nsym - 1) begin
                    est  = 3'd3;
                    ectr = 3'(k - 1);
                end else begin
                    est  = 3'd4;
                    ectr = 3'(2 * nsym - 2 - k);
                end
                if ({st[d], ctr[d]} !== {est, ectr}) bad++;
                if (cntv[d] !== 1'b0) bad++;
                if (pc[d] !== 7'(e.pix)) bad++;
            end
        end
        chk("latency", k, e.lat);
        chk("sort_decode_seq", bad, 0);
        chk("codev", {20'd0, st[d], ctr[d], pc[d], ovf_o[d]}, {20'd0, 3'd5, 3'd0, 7'(e.pix), e.ovf});

        if (hold > 0) begin
            ack[d] = 1'b0;
            bad = 0;
            for (int h = 0; h < hold; h++) begin
                @(negedge clk);
                if ({cv[d], st[d]} !== {1'b1, 3'd5}) bad++;
            end
            chk("hold_codev", bad, 0);
            ack[d] = 1'b1;
            @(negedge clk);
            chk("ack_release", {27'd0, cv[d], st[d], busy_o[d]}, 32'd0);
            ack[d] = 1'b0;
        end else begin
            // gray_valid in CODEV must not start an image; ack is don't-care
            gv[d]  = tog;
            ack[d] = 1'b1;
            @(negedge clk);
            chk("codev_end", {20'd0, cv[d], st[d], busy_o[d], pc[d]}, {20'd0, 1'b0, 3'd0, 1'b0, 7'(e.pix)});
            gv[d]  = 1'b0;
            ack[d] = 1'b0;
            @(negedge clk);
            chk("idle_stays", {29'd0, st[d]}, 32'd0);
        end
    endtask

    initial begin
        bit found;
        for (int d = 0; d < 3; d++) begin
            gv[d]  = 1'b0;
            ack[d] = 1'b0;
        end
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        for (int d = 0; d < 3; d++) chk("reset_state", outs(d), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Basic 10-pixel image, default parameters
        run_image(0, 10, 6, 0, 1'b0);
        // Held code_valid released by code_ack after 5 cycles
        run_image(1, 10, 6, 5, 1'b0);
        // Saturation and overflow, then overflow cleared by the next image
        run_image(0, 105, 6, 0, 1'b0);
        chk("ovf_held_idle", {31'd0, ovf_o[0]}, 32'd1);
        run_image(0, 3, 6, 0, 1'b0);
        // Eight symbols: longer sort/decode walk
        run_image(2, 7, 8, 0, 1'b0);

        // Asynchronous reset in the middle of DECODE
        @(negedge clk);
        gv[0] = 1'b1;
        repeat (4) @(negedge clk);
        gv[0] = 1'b0;
        found = 1'b0;
        for (int w = 0; w < 40 && !found; w++) begin
            @(negedge clk);
            found = (st[0] == 3'd4) && (ctr[0] == 3'd2);
        end
        chk("reach_decode2", {31'd0, found}, 32'd1);
        #2 rst_n = 1'b0;
        #1 chk("async_reset", outs(0), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_image(0, 4, 6, 0, 1'b0);

        // Single-pixel image with gray_valid toggling in SORT/DECODE/CODEV
        run_image(0, 1, 6, 0, 1'b1);

        chk("sb_empty", sb.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "bench did not complete");
    end

endmodule
